sata_phyinit_mlane: RTL and testbench
=====================================

# sata_phyinit_mlane

Multi-lane, parametrised successor to the single-lane SATA PHY reset/init sequencer. It sits between the register/link layer and one shared PLL plus NLANES GTX transceivers. It steps the PLL and a per-lane-masked set of transceivers through power-down, reset, user-ready and CDR-settle phases. It adds a bounded retry policy with a sticky fatal state and recovery from lane drop-out while up.

## Interface
Parameters:
- NLANES, 2: number of transceiver lanes (1..8).
- PWRDN_CYCLES, 100: hold time in FSM_POWER_DOWN.
- PLL_RST_CYCLES, 4: PLL reset pulse width.
- GTX_RST_CYCLES, 50: minimum GTX reset width.
- CDR_LG, 11: CDR settle time is 2**CDR_LG cycles.
- WDOG_LG, 20: watchdog period is 2**WDOG_LG cycles.
- MAX_RETRIES, 3: watchdog timeouts tolerated before FAULT (1..15).

Ports:
- i_clk  in  1  sole clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_power_down  in  1  synchronous; forces FSM_POWER_DOWN while high.
- i_lane_en  in  NLANES  lane participation mask; sampled on entry to FSM_GTX_RESET.
- o_pll_reset  out  1  shared PLL reset.
- i_pll_locked  in  1  asynchronous; 2-flop synchronised internally.
- o_gtx_reset  out  NLANES  per-lane transceiver reset.
- i_gtx_reset_done  in  NLANES  asynchronous; 2-flop synchronised per lane.
- o_user_ready  out  NLANES  per-lane USERRDY.
- o_complete  out  1  all enabled lanes up.
- o_err  out  1  one-cycle pulse per watchdog timeout.
- o_fatal  out  1  sticky; retry budget exhausted.
- o_retries  out  4  timeouts since last READY.
- o_state  out  4  current FSM state encoding.

## Operation
- States and encodings: POWER_DOWN=0, PLL_RESET=1, PLL_WAIT=2, GTX_RESET=3, USER_READY=4, GTX_WAIT=5, CDR_WAIT=6, READY=8, FAULT=15.
- One down-counter loads on every state entry. `zero` means the counter has reached 0.
- POWER_DOWN: pll and all gtx resets asserted. Load PWRDN_CYCLES. On zero, go to PLL_RESET.
- PLL_RESET: pll and gtx resets asserted. Load PLL_RST_CYCLES. On zero, release pll reset and go to PLL_WAIT.
- PLL_WAIT: gtx resets asserted. Load 4. On zero and synced lock, go to GTX_RESET.
- GTX_RESET: latch `mask = i_lane_en` on entry and assert gtx reset on all lanes. Load GTX_RST_CYCLES.
  - Exit requires zero, mask≠0, and synced done low on every masked lane.
  - On exit, release gtx reset on masked lanes only and go to USER_READY.
  - If mask==0, remain here; watchdog is held cleared.
- USER_READY: load 4. On zero, go to GTX_WAIT.
- GTX_WAIT: o_user_ready = mask. Load 4. Once zero and done is high on all masked lanes, go to CDR_WAIT.
- CDR_WAIT: user_ready held. Wait 2**CDR_LG cycles, then go to READY.
- READY: o_complete=1, user_ready held, retries cleared.
- Unmasked lanes: gtx_reset=1 and user_ready=0 at all times outside POWER_DOWN/PLL phases.
- Priority of overrides, highest first (apply in every state):
  1. Lock loss in states 3..8 → PLL_RESET. Not counted as a retry.
  2. Done falling on any masked lane while in READY → GTX_RESET. Not counted as a retry.
  3. Watchdog timeout in states 4..6 → o_err pulse and retries+1. If retries+1 == MAX_RETRIES go to FAULT, else GTX_RESET.
- Watchdog: WDOG_LG+1-bit counter. Runs in states 3..6. Cleared in READY, in FAULT, in states <3, and on every timeout.
- FAULT: all resets asserted, user_ready=0, o_fatal=1. Exit only via i_reset or i_power_down.
- i_power_down has priority over everything except i_reset. It clears o_fatal and retries.

## Timing
- Reset values: o_pll_reset=1, o_gtx_reset=all-1, o_user_ready=0, o_complete=0, o_err=0, o_fatal=0, o_retries=0, o_state=0.
- All outputs are registered. Each output changes on the clock edge that enters a state (1-cycle latency from the decision).
- Synchronised inputs lag the pins by 2 cycles. Lock loss reaches o_pll_reset no later than 3 cycles after the pin falls.
- o_err is high exactly one cycle per timeout, on the same edge that updates o_retries and o_state.
- Reset asserted mid-sequence forces reset values immediately (asynchronously). The sequence restarts at POWER_DOWN after deassertion.
- Simultaneous lock loss and timeout: lock loss wins, with no o_err and no retry increment.

## Test plan
- Nominal bring-up, NLANES=2, mask=2'b11: lock at 150, done high 20 cycles after gtx release → o_complete=1. Verify the 100/4/50-cycle minimum widths and CDR wait of 2048 cycles.
- Mask 2'b01: lane 1 held at gtx_reset=1 and user_ready=0; lane 0 alone reaches READY with o_complete=1.
- Done never rises, WDOG_LG=8, MAX_RETRIES=3 → o_err pulses at cycles 256/512/768 after entering state 3. o_retries counts 1,2, then FAULT with o_fatal=1. i_power_down clears it.
- i_pll_locked drops while in READY → o_complete low and state=1 within 3 cycles. Re-lock → READY again with retries=0.
- Lane 1 done falls while in READY → GTX_RESET with all gtx_reset=1 and no o_err. Done restored → READY.
- i_reset pulsed during CDR_WAIT → all outputs take reset values the same cycle. The full sequence repeats from POWER_DOWN.

Source files
------------

// File: rtl/sata_phyinit_mlane.sv
// Multi-lane SATA PHY reset/init sequencer: steps a shared PLL and NLANES GTX
// transceivers through power-down, reset, USERRDY and CDR settle, with a bounded watchdog retry policy.
module sata_phyinit_mlane #(
    parameter int NLANES         = 2,
    parameter int PWRDN_CYCLES   = 100,
    parameter int PLL_RST_CYCLES = 4,
    parameter int GTX_RST_CYCLES = 50,
    parameter int CDR_LG         = 11,
    parameter int WDOG_LG        = 20,
    parameter int MAX_RETRIES    = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_power_down,
    input  logic [NLANES-1:0] i_lane_en,
    output logic              o_pll_reset,
    input  logic              i_pll_locked,
    output logic [NLANES-1:0] o_gtx_reset,
    input  logic [NLANES-1:0] i_gtx_reset_done,
    output logic [NLANES-1:0] o_user_ready,
    output logic              o_complete,
    output logic              o_err,
    output logic              o_fatal,
    output logic [3:0]        o_retries,
    output logic [3:0]        o_state
);

    localparam logic [3:0] FSM_POWER_DOWN = 4'd0;
    localparam logic [3:0] FSM_PLL_RESET  = 4'd1;
    localparam logic [3:0] FSM_PLL_WAIT   = 4'd2;
    localparam logic [3:0] FSM_GTX_RESET  = 4'd3;
    localparam logic [3:0] FSM_USER_READY = 4'd4;
    localparam logic [3:0] FSM_GTX_WAIT   = 4'd5;
    localparam logic [3:0] FSM_CDR_WAIT   = 4'd6;
    localparam logic [3:0] FSM_READY      = 4'd8;
    localparam logic [3:0] FSM_FAULT      = 4'd15;

    localparam int CDR_CYCLES = 1 << CDR_LG;
    localparam int MAX_A      = (PWRDN_CYCLES > GTX_RST_CYCLES) ? PWRDN_CYCLES : GTX_RST_CYCLES;
    localparam int MAX_B      = (MAX_A > CDR_CYCLES) ? MAX_A : CDR_CYCLES;
    localparam int MAX_C      = (MAX_B > PLL_RST_CYCLES) ? MAX_B : PLL_RST_CYCLES;
    localparam int MAX_D      = (MAX_C > 4) ? MAX_C : 4;
    localparam int CNT_W      = $clog2(MAX_D + 1);

    localparam logic [WDOG_LG:0] WDOG_LAST = {1'b0, {WDOG_LG{1'b1}}};

    // The counter holds (cycles - 1) so a state loaded with N lasts exactly N cycles.
    function automatic logic [CNT_W-1:0] load_val(input logic [3:0] s);
        case (s)
            FSM_POWER_DOWN: load_val = CNT_W'(PWRDN_CYCLES - 1);
            FSM_PLL_RESET:  load_val = CNT_W'(PLL_RST_CYCLES - 1);
            FSM_PLL_WAIT:   load_val = CNT_W'(3);
            FSM_GTX_RESET:  load_val = CNT_W'(GTX_RST_CYCLES - 1);
            FSM_USER_READY: load_val = CNT_W'(3);
            FSM_GTX_WAIT:   load_val = CNT_W'(3);
            FSM_CDR_WAIT:   load_val = CNT_W'(CDR_CYCLES - 1);
            default:        load_val = '0;
        endcase
    endfunction

    logic              r_lock_meta;
    logic              r_lock_sync;
    logic [NLANES-1:0] r_done_meta;
    logic [NLANES-1:0] r_done_sync;

    logic [3:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WDOG_LG:0]  r_wdog;
    logic [NLANES-1:0] r_mask;
    logic [3:0]        r_retries;
    logic              r_pll_reset;
    logic [NLANES-1:0] r_gtx_reset;
    logic [NLANES-1:0] r_user_ready;
    logic              r_complete;
    logic              r_err;
    logic              r_fatal;

    logic [3:0]        w_state_n;
    logic [3:0]        w_retries_n;
    logic              w_err_n;
    logic [NLANES-1:0] w_mask_n;
    logic [CNT_W-1:0]  w_cnt_n;
    logic [WDOG_LG:0]  w_wdog_n;
    logic              w_pll_reset_n;
    logic [NLANES-1:0] w_gtx_reset_n;
    logic [NLANES-1:0] w_user_ready_n;

    logic              w_zero;
    logic              w_lock_loss;
    logic              w_done_lost;
    logic              w_wdog_hit;
    logic              w_timeout;
    logic              w_wdog_run;
    logic              w_entry;
    logic [NLANES-1:0] w_done_masked;
    logic [3:0]        w_retries_inc;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_done_meta <= '0;
            r_done_sync <= '0;
        end else begin
            r_lock_meta <= i_pll_locked;
            r_lock_sync <= r_lock_meta;
            r_done_meta <= i_gtx_reset_done;
            r_done_sync <= r_done_meta;
        end
    end

    assign w_zero        = (r_cnt == '0);
    assign w_done_masked = r_done_sync & r_mask;
    assign w_retries_inc = r_retries + 4'd1;
    assign w_lock_loss   = (r_state >= FSM_GTX_RESET) && (r_state <= FSM_READY) && !r_lock_sync;
    assign w_done_lost   = (r_state == FSM_READY) && (w_done_masked != r_mask);
    assign w_wdog_hit    = (r_wdog == WDOG_LAST);
    assign w_timeout     = w_wdog_hit && (r_state >= FSM_USER_READY) && (r_state <= FSM_CDR_WAIT);

    // Overrides are ordered: power-down, lock loss, lane drop in READY, watchdog.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_state_n   = r_state;
        w_retries_n = r_retries;
        w_err_n     = 1'b0;
        if (i_power_down) begin
            w_state_n   = FSM_POWER_DOWN;
            w_retries_n = '0;
        end else if (w_lock_loss) begin
            w_state_n = FSM_PLL_RESET;
        end else if (w_done_lost) begin
            w_state_n = FSM_GTX_RESET;
        end else if (w_timeout) begin
            w_err_n     = 1'b1;
            w_retries_n = w_retries_inc;
            w_state_n   = (w_retries_inc == 4'(MAX_RETRIES)) ? FSM_FAULT : FSM_GTX_RESET;
        end else begin
            case (r_state)
                FSM_POWER_DOWN: if (w_zero) w_state_n = FSM_PLL_RESET;
                FSM_PLL_RESET:  if (w_zero) w_state_n = FSM_PLL_WAIT;
                FSM_PLL_WAIT:   if (w_zero && r_lock_sync) w_state_n = FSM_GTX_RESET;
                FSM_GTX_RESET: begin
                    if (w_zero && (r_mask != '0) && (w_done_masked == '0))
                        w_state_n = FSM_USER_READY;
                end
                FSM_USER_READY: if (w_zero) w_state_n = FSM_GTX_WAIT;
                FSM_GTX_WAIT: begin
                    if (w_zero && (w_done_masked == r_mask))
                        w_state_n = FSM_CDR_WAIT;
                end
                FSM_CDR_WAIT:   if (w_zero) w_state_n = FSM_READY;
                FSM_READY:      w_state_n = FSM_READY;
                FSM_FAULT:      w_state_n = FSM_FAULT;
                default:        w_state_n = FSM_POWER_DOWN;
            endcase
        end
        if (w_state_n == FSM_READY)
            w_retries_n = '0;
    end

    assign w_entry  = (w_state_n != r_state) || i_power_down;
    assign w_mask_n = ((w_state_n == FSM_GTX_RESET) && (r_state != FSM_GTX_RESET)) ? i_lane_en : r_mask;
    assign w_cnt_n  = w_entry ? load_val(w_state_n) : (w_zero ? r_cnt : r_cnt - 1'b1);

    // Watchdog only runs while staying in states 3..6; an empty mask parks it at zero.
    assign w_wdog_run = (r_state >= FSM_GTX_RESET) && (r_state <= FSM_CDR_WAIT)
                     && (w_state_n >= FSM_GTX_RESET) && (w_state_n <= FSM_CDR_WAIT)
                     && !((r_state == FSM_GTX_RESET) && (r_mask == '0))
                     && !w_wdog_hit;
    assign w_wdog_n   = w_wdog_run ? r_wdog + 1'b1 : '0;

    always_comb begin
        w_pll_reset_n  = (w_state_n == FSM_POWER_DOWN) || (w_state_n == FSM_PLL_RESET)
                      || (w_state_n == FSM_FAULT);
        w_gtx_reset_n  = '1;
        w_user_ready_n = '0;
        case (w_state_n)
            FSM_USER_READY: w_gtx_reset_n = ~w_mask_n;
            FSM_GTX_WAIT, FSM_CDR_WAIT, FSM_READY: begin
                w_gtx_reset_n  = ~w_mask_n;
                w_user_ready_n = w_mask_n;
            end
            default: begin
                w_gtx_reset_n  = '1;
                w_user_ready_n = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= FSM_POWER_DOWN;
            r_cnt        <= load_val(FSM_POWER_DOWN);
            r_wdog       <= '0;
            r_mask       <= '0;
            r_retries    <= '0;
            r_pll_reset  <= 1'b1;
            r_gtx_reset  <= '1;
            r_user_ready <= '0;
            r_complete   <= 1'b0;
            r_err        <= 1'b0;
            r_fatal      <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_wdog       <= w_wdog_n;
            r_mask       <= w_mask_n;
            r_retries    <= w_retries_n;
            r_pll_reset  <= w_pll_reset_n;
            r_gtx_reset  <= w_gtx_reset_n;
            r_user_ready <= w_user_ready_n;
            r_complete   <= (w_state_n == FSM_READY);
            r_err        <= w_err_n;
            r_fatal      <= (w_state_n == FSM_FAULT);
        end
    end

    assign o_pll_reset  = r_pll_reset;
    assign o_gtx_reset  = r_gtx_reset;
    assign o_user_ready = r_user_ready;
    assign o_complete   = r_complete;
    assign o_err        = r_err;
    assign o_fatal      = r_fatal;
    assign o_retries    = r_retries;
    assign o_state      = r_state;

endmodule

// File: tb/tb_sata_phyinit_mlane.sv
// Directed bench for sata_phyinit_mlane: mask table plus hand-written bring-up,
// watchdog/fault, lock-loss, lane-drop and mid-sequence reset sequences.
module tb_sata_phyinit_mlane;

    localparam int WDOG_LG = 12;
    localparam int WDOG_T  = 1 << WDOG_LG;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_power_down;
    logic [1:0] i_lane_en;
    logic       o_pll_reset;
    logic       i_pll_locked;
    logic [1:0] o_gtx_reset;
    logic [1:0] gtx_done = 2'b00;
    logic [1:0] o_user_ready;
    logic       o_complete;
    logic       o_err;
    logic       o_fatal;
    logic [3:0] o_retries;
    logic [3:0] o_state;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    logic [1:0] done_force_low = 2'b00;
    int done_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    sata_phyinit_mlane #(
        .NLANES(2), .PWRDN_CYCLES(100), .PLL_RST_CYCLES(4), .GTX_RST_CYCLES(50),
        .CDR_LG(11), .WDOG_LG(WDOG_LG), .MAX_RETRIES(3)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_power_down(i_power_down), .i_lane_en(i_lane_en),
        .o_pll_reset(o_pll_reset), .i_pll_locked(i_pll_locked), .o_gtx_reset(o_gtx_reset),
        .i_gtx_reset_done(gtx_done), .o_user_ready(o_user_ready), .o_complete(o_complete),
        .o_err(o_err), .o_fatal(o_fatal), .o_retries(o_retries), .o_state(o_state)
    );

    // Transceiver model: done rises 20 cycles after its reset is released.
    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (o_gtx_reset[l] || done_force_low[l]) begin
                done_cnt[l] <= 0;
                gtx_done[l] <= 1'b0;
            end else if (done_cnt[l] < 20) begin
                done_cnt[l] <= done_cnt[l] + 1;
            end else begin
                gtx_done[l] <= 1'b1;
            end
        end
    end

    always @(negedge clk) if (o_err === 1'b1) err_seen++;

    typedef struct {
        logic [1:0] lane_en;
        logic [3:0] exp_state;
        int         hold;
        logic [1:0] exp_gtx_reset;
        logic [1:0] exp_user_ready;
        logic       exp_complete;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, output int n);
        n = 0;
        while (o_state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (o_state !== s) n = -1;
    endtask

    task automatic dur(input logic [3:0] s, input int budget, output int n);
        int w;
        wait_state(s, budget, w);
        n = 0;
        if (w < 0) begin
            n = -1;
            return;
        end
        while (o_state === s && n < budget) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_err(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_err !== 1'b1 && n < budget);
    endtask

    task automatic pulse_pd();
        @(negedge clk);
        i_power_down = 1'b1;
        @(negedge clk);
        i_power_down = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_reset"}, o_pll_reset, 1'b1);
        check({tag, "_gtx_reset"}, o_gtx_reset, 2'b11);
        check({tag, "_user_ready"}, o_user_ready, 2'b00);
        check({tag, "_complete"}, o_complete, 1'b0);
        check({tag, "_err"}, o_err, 1'b0);
        check({tag, "_fatal"}, o_fatal, 1'b0);
        check({tag, "_retries"}, o_retries, 4'd0);
        check({tag, "_state"}, o_state, 4'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int e0;

        vecs[0] = '{2'b11, 4'd8, 300,  2'b00, 2'b11, 1'b1};
        vecs[1] = '{2'b01, 4'd8, 300,  2'b10, 2'b01, 1'b1};
        vecs[2] = '{2'b10, 4'd8, 300,  2'b01, 2'b10, 1'b1};
        vecs[3] = '{2'b00, 4'd3, 5000, 2'b11, 2'b00, 1'b0};

        i_reset      = 1'b1;
        i_power_down = 1'b0;
        i_lane_en    = 2'b11;
        i_pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");

        // Nominal bring-up with exact phase widths.
        i_reset = 1'b0;
        dur(4'd0, 300, n);   check("pwrdn_width", n, 100);
        dur(4'd1, 50, n);    check("pll_rst_width", n, 4);
        repeat (44) @(negedge clk);
        check("pll_wait_no_lock", o_state, 4'd2);
        check("pll_wait_pll_reset", o_pll_reset, 1'b0);
        check("pll_wait_gtx_reset", o_gtx_reset, 2'b11);
        i_pll_locked = 1'b1;
        dur(4'd3, 200, n);   check("gtx_rst_width", n, 50);
        dur(4'd4, 50, n);    check("user_ready_width", n, 4);
        check("gtx_wait_state", o_state, 4'd5);
        check("gtx_wait_user_ready", o_user_ready, 2'b11);
        check("gtx_wait_gtx_reset", o_gtx_reset, 2'b00);
        dur(4'd6, 3000, n);  check("cdr_width", n, 2048);
        check("nom_state", o_state, 4'd8);
        check("nom_complete", o_complete, 1'b1);
        check("nom_retries", o_retries, 4'd0);
        check("nom_err_count", err_seen, 0);

        // Lane mask table.
        for (int i = 0; i < 4; i++) begin
            i_lane_en = vecs[i].lane_en;
            pulse_pd();
            wait_state(vecs[i].exp_state, 4000, n);
            e0 = err_seen;
            repeat (vecs[i].hold) @(negedge clk);
            check($sformatf("vec%0d_state", i), o_state, vecs[i].exp_state);
            check($sformatf("vec%0d_gtx_reset", i), o_gtx_reset, vecs[i].exp_gtx_reset);
            check($sformatf("vec%0d_user_ready", i), o_user_ready, vecs[i].exp_user_ready);
            check($sformatf("vec%0d_complete", i), o_complete, vecs[i].exp_complete);
            check($sformatf("vec%0d_no_err", i), err_seen - e0, 0);
        end

        // Lock loss while READY, then re-lock.
        i_lane_en = 2'b11;
        pulse_pd();
        wait_state(4'd8, 4000, n);
        check("ll_ready", o_state, 4'd8);
        e0 = err_seen;
        i_pll_locked = 1'b0;
        n = 0;
        while (o_state !== 4'd1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ll_latency_le3", (n >= 1 && n <= 3), 1'b1);
        check("ll_pll_reset", o_pll_reset, 1'b1);
        check("ll_complete_low", o_complete, 1'b0);
        i_pll_locked = 1'b1;
        wait_state(4'd8, 4000, n);
        check("ll_relock_state", o_state, 4'd8);
        check("ll_relock_retries", o_retries, 4'd0);
        check("ll_no_err", err_seen - e0, 0);

        // Lane 1 drops while READY.
        done_force_low = 2'b10;
        wait_state(4'd3, 20, n);
        check("drop_state", o_state, 4'd3);
        check("drop_gtx_reset", o_gtx_reset, 2'b11);
        check("drop_complete", o_complete, 1'b0);
        done_force_low = 2'b00;
        wait_state(4'd8, 4000, n);
        check("drop_recover_state", o_state, 4'd8);
        check("drop_recover_complete", o_complete, 1'b1);
        check("drop_no_err", err_seen - e0, 0);

        // Done never rises: three watchdog timeouts then sticky FAULT.
        done_force_low = 2'b11;
        pulse_pd();
        wait_state(4'd3, 400, n);
        check("wd_enter_gtx_reset", o_state, 4'd3);
        wait_err(WDOG_T + 100, n);
        check("wd_t1_cycles", n, WDOG_T);
        check("wd_t1_retries", o_retries, 4'd1);
        check("wd_t1_state", o_state, 4'd3);
        wait_err(WDOG_T + 100, n);
        check("wd_t2_cycles", n, WDOG_T);
        check("wd_t2_retries", o_retries, 4'd2);
        wait_err(WDOG_T + 100, n);
        check("wd_t3_cycles", n, WDOG_T);
        check("wd_fault_state", o_state, 4'd15);
        check("wd_fault_fatal", o_fatal, 1'b1);
        check("wd_fault_retries", o_retries, 4'd3);
        check("wd_fault_gtx_reset", o_gtx_reset, 2'b11);
        check("wd_fault_pll_reset", o_pll_reset, 1'b1);
        check("wd_fault_user_ready", o_user_ready, 2'b00);
        @(negedge clk);
        check("wd_err_one_cycle", o_err, 1'b0);
        done_force_low = 2'b00;
        repeat (200) @(negedge clk);
        check("wd_fault_sticky", o_state, 4'd15);
        pulse_pd();
        check("pd_state", o_state, 4'd0);
        check("pd_fatal_clear", o_fatal, 1'b0);
        check("pd_retries_clear", o_retries, 4'd0);

        // Asynchronous reset during CDR_WAIT, then a full restart.
        wait_state(4'd6, 4000, n);
        check("rc_cdr_state", o_state, 4'd6);
        repeat (10) @(negedge clk);
        #2 i_reset = 1'b1;
        #1 check_reset_values("mid_rst");
        @(negedge clk);
        i_reset = 1'b0;
        dur(4'd0, 300, n);
        check("rc_pwrdn_width", n, 100);
        wait_state(4'd8, 4000, n);
        check("rc_ready_state", o_state, 4'd8);
        check("rc_complete", o_complete, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
